warp_scheduler: RTL
===================

Name: warp_scheduler

Overview:
- Issue-select stage directly downstream of the per-warp context store.
- Consumes all warp contexts plus per-warp scoreboard stalls, and picks one eligible warp per issue slot using greedy-then-oldest (GTO) arbitration.
- Offers the chosen warp's id/pc/mask to fetch over a valid/ready handshake.
- Returns warp_issued/issued_warp_id to the context store for age tracking.

Parameters:
- NUM_WARPS, WARPS_PER_CORE (4): warps arbitrated.
- MAX_GREEDY, 4: max consecutive issues of one warp before forced oldest-first reselect (1..15).

Ports:
- clk  in  1  single clock.
- rst  in  1  asynchronous, active-high reset.
- sched_en  in  1  permits new selections; an offer already made is unaffected.
- contexts  in  warp_context_t[NUM_WARPS]  pc, active_mask, status, age, valid per warp.
- scoreboard_stall  in  NUM_WARPS  warp i not issuable this cycle.
- issue_valid  out  1  offer valid.
- issue_ready  in  1  fetch accepts offer.
- issue_warp_id  out  WARP_ID_WIDTH  offered warp.
- issue_pc  out  DATA_WIDTH  offered warp PC.
- issue_mask  out  WARP_SIZE  offered active mask.
- warp_issued  out  1  handshake fire (issue_valid && issue_ready).
- issued_warp_id  out  WARP_ID_WIDTH  equals issue_warp_id.
- all_done  out  1  every valid warp is DONE and at least one warp is valid.

Behaviour:
- Eligibility: eligible[i] = contexts[i].valid && status==WARP_READY && !scoreboard_stall[i].
- Reset values:
  - issue_valid=0, issue_warp_id/pc/mask=0, all_done=0.
  - state=SEL, last_id=0, greedy_cnt=0.
  - Reset asserted mid-offer clears issue_valid immediately (asynchronous).
- State SEL:
  - If sched_en and any eligible: register selection into issue_* and set issue_valid at next edge; go to OFFER.
  - Otherwise stay in SEL.
  - Latency: eligibility sampled in cycle N, offer visible in N+1.
- Selection order:
  1. Greedy: last_id, if eligible and greedy_cnt < MAX_GREEDY.
  2. Otherwise the eligible warp with the largest age. Age ties go to the first index found scanning upward from last_id+1 (mod NUM_WARPS). last_id itself is a candidate at the lowest rotational priority.
- State OFFER:
  - issue_id/pc/mask held stable while issue_valid=1 and ready=0.
  - Fire (valid && ready): warp_issued=1 in that same cycle (combinational from registered valid and ready). Next edge: issue_valid=0, state=SEL.
  - On fire: if issued id == last_id, greedy_cnt saturates-increments (4-bit, caps at 15); else greedy_cnt=1 and last_id=issued id.
  - A fire cycle always creates one bubble, so the context store's PC/age updates are visible before the next select. Peak rate is one issue per 2 cycles.
- Retract, with issue_valid=1 and ready=0:
  - If the offered warp's status leaves READY or its valid drops, issue_valid=0 at next edge and state=SEL. No warp_issued.
  - scoreboard_stall on the offered warp does NOT retract.
  - sched_en low does NOT retract.
- Simultaneous fire and status change in the same cycle: fire wins; warp_issued=1.
- all_done:
  - Registered, updated every cycle.
  - While all_done=1, SEL makes no offers (no warp is eligible anyway).
- Age compare is unsigned 8-bit; saturated ages (FF) tie and fall to rotational order.

Decomposition:
- pkg_opengpu additions:
  - sched_state_t enum {SCHED_SEL, SCHED_OFFER}.
  - GREEDY_CNT_WIDTH=4 and MAX_GREEDY default constant.
- Existing pkg_opengpu content reused: warp_context_t, warp_status_t, WARP_ID_WIDTH, DATA_WIDTH, WARP_SIZE.
- One sub-module: warp_oldest_select.
  - Combinational: eligible mask, ages[], rotate base → oldest id + found flag.
  - Instantiated once; the greedy check and FSM stay in the top module.

Test Plan:
1. Rst pulse, then warps 0-3 valid READY, age 0, pcs 0x100/0x200/0x300/0x400, last_id=0 → offer warp 1 (rotation from last_id+1), issue_pc=0x200, issue_valid rises one cycle after eligibility.
2. MAX_GREEDY=4, warp 1 issued and kept eligible with ready=1 → four consecutive fires of warp 1. Then, with ages w2=7, w3=3, the next offer is warp 2 and greedy_cnt=1.
3. issue_ready low 5 cycles during offer of warp 3 → id/pc/mask unchanged and warp_issued=0 throughout. Ready high → exactly one warp_issued pulse with issued_warp_id=3, issue_valid=0 next cycle.
4. Offer warp 2 with ready=0:
   - Set status BLOCKED → issue_valid drops the next cycle, no fire.
   - Repeat with scoreboard_stall[2]=1 only → offer persists.
5. Warps 0 and 3 eligible, both age 5, last_id=2, greedy ineligible → warp 3 chosen. With last_id=3 and greedy_cnt=MAX_GREEDY → warp 0 chosen.
6. All valid warps DONE → all_done=1 one cycle later with issue_valid=0. Assert rst mid-offer → issue_valid=0 asynchronously with no clock edge; all_done=0.

Source files
------------

// File: rtl/warp_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// warp_scheduler_pkg
//   Shared types and constants for the warp issue-select stage: warp context
//   layout, warp status encoding, scheduler FSM states, greedy counter sizing
//   and a saturating-increment helper for the greedy counter.
// -----------------------------------------------------------------------------
package warp_scheduler_pkg;

  localparam int WARPS_PER_CORE     = 4;
  localparam int WARP_ID_WIDTH      = $clog2(WARPS_PER_CORE);
  localparam int DATA_WIDTH         = 32;
  localparam int WARP_SIZE          = 32;
  localparam int AGE_WIDTH          = 8;
  localparam int GREEDY_CNT_WIDTH   = 4;
  localparam int MAX_GREEDY_DEFAULT = 4;

  typedef enum logic [1:0] {
    WARP_IDLE    = 2'd0,
    WARP_READY   = 2'd1,
    WARP_BLOCKED = 2'd2,
    WARP_DONE    = 2'd3
  } warp_status_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] pc;
    logic [WARP_SIZE-1:0]  active_mask;
    warp_status_t          status;
    logic [AGE_WIDTH-1:0]  age;
    logic                  valid;
  } warp_context_t;

  typedef enum logic {
    SCHED_SEL   = 1'b0,
    SCHED_OFFER = 1'b1
  } sched_state_t;

  // Greedy run length counter: sticks at all-ones instead of wrapping.
  function automatic logic [GREEDY_CNT_WIDTH-1:0] greedy_sat_inc(
    input logic [GREEDY_CNT_WIDTH-1:0] cnt
  );
    return (cnt == '1) ? cnt : cnt + GREEDY_CNT_WIDTH'(1);
  endfunction

endpackage

// File: rtl/warp_oldest_select.sv
// -----------------------------------------------------------------------------
// warp_oldest_select
//   Purely combinational oldest-first picker. Scans warps in rotational order
//   starting at base_i and returns the eligible warp with the strictly largest
//   age; equal ages keep the first one met in the scan, so the warp just
//   before base_i has the lowest priority among ties.
//
// Ports:
//   eligible_i   [NUM_WARPS]   warp may be issued this cycle
//   ages_i       [NUM_WARPS]   unsigned warp ages
//   base_i                     first index of the rotational scan
//   oldest_id_o                selected warp (0 when none found)
//   found_o                    at least one warp is eligible
// -----------------------------------------------------------------------------
module warp_oldest_select
  import warp_scheduler_pkg::*;
#(
  parameter int NUM_WARPS = WARPS_PER_CORE
) (
  input  logic [NUM_WARPS-1:0]     eligible_i,
  input  logic [AGE_WIDTH-1:0]     ages_i [NUM_WARPS],
  input  logic [WARP_ID_WIDTH-1:0] base_i,
  output logic [WARP_ID_WIDTH-1:0] oldest_id_o,
  output logic                     found_o
);

  // (base + offset) mod NUM_WARPS without a divider; offset < NUM_WARPS.
  function automatic logic [WARP_ID_WIDTH-1:0] rot_index(
    input logic [WARP_ID_WIDTH-1:0] base,
    input int unsigned              offset
  );
    int unsigned sum;
    sum = 32'(base) + offset;
    if (sum >= 32'(NUM_WARPS)) sum = sum - 32'(NUM_WARPS);
    return sum[WARP_ID_WIDTH-1:0];
  endfunction

  logic [WARP_ID_WIDTH-1:0] idx;
  logic [AGE_WIDTH-1:0]     best_age;

  always_comb begin
    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment, otherwise synthesis infers a latch.
    found_o     = 1'b0;
    oldest_id_o = '0;
    best_age    = '0;
    idx         = '0;
    for (int unsigned k = 0; k < NUM_WARPS; k++) begin
      idx = rot_index(base_i, k);
      // Strict '>' keeps the earlier warp on equal (including saturated) ages.
      if (eligible_i[idx] && (!found_o || (ages_i[idx] > best_age))) begin
        found_o     = 1'b1;
        oldest_id_o = idx;
        best_age    = ages_i[idx];
      end
    end
  end

endmodule

// File: rtl/warp_scheduler.sv
// -----------------------------------------------------------------------------
// warp_scheduler
//   Issue-select stage behind the per-warp context store. Picks one eligible
//   warp per issue slot with greedy-then-oldest arbitration and offers its
//   id/pc/mask to fetch over a valid/ready handshake. Each accepted offer is
//   followed by one idle cycle so the context store's pc/age updates land
//   before the next selection.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   sched_en_i            allow new selections (does not cancel a live offer)
//   contexts_i            per-warp pc, active mask, status, age, valid
//   scoreboard_stall_i    per-warp stall for this cycle
//   issue_valid_o         offer valid
//   issue_ready_i         fetch accepts the offer
//   issue_warp_id_o       offered warp id
//   issue_pc_o            offered warp pc
//   issue_mask_o          offered warp active mask
//   warp_issued_o         handshake fire (valid && ready), combinational
//   issued_warp_id_o      id of the warp that fired
//   all_done_o            every valid warp is DONE and at least one is valid
// -----------------------------------------------------------------------------
module warp_scheduler
  import warp_scheduler_pkg::*;
#(
  parameter int NUM_WARPS  = WARPS_PER_CORE,
  parameter int MAX_GREEDY = MAX_GREEDY_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     sched_en_i,
  input  warp_context_t            contexts_i [NUM_WARPS],
  input  logic [NUM_WARPS-1:0]     scoreboard_stall_i,
  output logic                     issue_valid_o,
  input  logic                     issue_ready_i,
  output logic [WARP_ID_WIDTH-1:0] issue_warp_id_o,
  output logic [DATA_WIDTH-1:0]    issue_pc_o,
  output logic [WARP_SIZE-1:0]     issue_mask_o,
  output logic                     warp_issued_o,
  output logic [WARP_ID_WIDTH-1:0] issued_warp_id_o,
  output logic                     all_done_o
);

  localparam logic [GREEDY_CNT_WIDTH-1:0] MAX_GREEDY_C  = GREEDY_CNT_WIDTH'(MAX_GREEDY);
  localparam logic [WARP_ID_WIDTH-1:0]    LAST_WARP_C   = WARP_ID_WIDTH'(NUM_WARPS - 1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  sched_state_t                state_q,       state_d;
  logic                        issue_valid_q, issue_valid_d;
  logic [WARP_ID_WIDTH-1:0]    issue_id_q,    issue_id_d;
  logic [DATA_WIDTH-1:0]       issue_pc_q,    issue_pc_d;
  logic [WARP_SIZE-1:0]        issue_mask_q,  issue_mask_d;
  logic [WARP_ID_WIDTH-1:0]    last_id_q,     last_id_d;
  logic [GREEDY_CNT_WIDTH-1:0] greedy_cnt_q,  greedy_cnt_d;
  logic                        all_done_q,    all_done_d;

  // ---------------------------------------------------------------------------
  // Eligibility, ages and completion status
  // ---------------------------------------------------------------------------
  logic [NUM_WARPS-1:0] eligible;
  logic [AGE_WIDTH-1:0] ages [NUM_WARPS];
  logic                 any_valid;
  logic                 all_valid_done;

  always_comb begin
    any_valid      = 1'b0;
    all_valid_done = 1'b1;
    for (int i = 0; i < NUM_WARPS; i++) begin
      eligible[i] = contexts_i[i].valid
                 && (contexts_i[i].status == WARP_READY)
                 && !scoreboard_stall_i[i];
      ages[i]     = contexts_i[i].age;
      if (contexts_i[i].valid) begin
        any_valid = 1'b1;
        if (contexts_i[i].status != WARP_DONE) all_valid_done = 1'b0;
      end
    end
  end

  assign all_done_d = any_valid && all_valid_done;

  // ---------------------------------------------------------------------------
  // Greedy-then-oldest selection
  // ---------------------------------------------------------------------------
  logic [WARP_ID_WIDTH-1:0] rot_base;
  logic [WARP_ID_WIDTH-1:0] oldest_id;
  logic                     any_eligible;
  logic                     greedy_ok;
  logic [WARP_ID_WIDTH-1:0] sel_id;

  // Scan starts just after the last issued warp, which therefore sits at the
  // lowest rotational priority.
  assign rot_base = (last_id_q == LAST_WARP_C) ? '0 : last_id_q + WARP_ID_WIDTH'(1);

  warp_oldest_select #(
    .NUM_WARPS (NUM_WARPS)
  ) u_oldest_select (
    .eligible_i  (eligible),
    .ages_i      (ages),
    .base_i      (rot_base),
    .oldest_id_o (oldest_id),
    .found_o     (any_eligible)
  );

  // A zero count means nothing has issued since reset, so there is no warp to
  // stay greedy on yet; selection falls straight through to oldest-first.
  assign greedy_ok = eligible[last_id_q]
                  && (greedy_cnt_q != '0)
                  && (greedy_cnt_q < MAX_GREEDY_C);

  assign sel_id = greedy_ok ? last_id_q : oldest_id;

  // ---------------------------------------------------------------------------
  // Handshake and retract detection
  // ---------------------------------------------------------------------------
  warp_context_t offered_ctx;
  logic          fire;
  logic          retract;

  assign offered_ctx = contexts_i[issue_id_q];
  assign fire        = issue_valid_q && issue_ready_i;
  // Only loss of READY status or validity withdraws an offer; a scoreboard
  // stall or sched_en going low leaves it in place.
  assign retract     = !offered_ctx.valid || (offered_ctx.status != WARP_READY);

  // ---------------------------------------------------------------------------
  // FSM next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    issue_valid_d = issue_valid_q;
    issue_id_d    = issue_id_q;
    issue_pc_d    = issue_pc_q;
    issue_mask_d  = issue_mask_q;
    last_id_d     = last_id_q;
    greedy_cnt_d  = greedy_cnt_q;

    case (state_q)
      SCHED_SEL: begin
        if (sched_en_i && any_eligible && !all_done_q) begin
          issue_valid_d = 1'b1;
          issue_id_d    = sel_id;
          issue_pc_d    = contexts_i[sel_id].pc;
          issue_mask_d  = contexts_i[sel_id].active_mask;
          state_d       = SCHED_OFFER;
        end
      end
      SCHED_OFFER: begin
        // Fire takes priority over a same-cycle status change.
        if (fire) begin
          issue_valid_d = 1'b0;
          state_d       = SCHED_SEL;
          if (issue_id_q == last_id_q) begin
            greedy_cnt_d = greedy_sat_inc(greedy_cnt_q);
          end else begin
            greedy_cnt_d = GREEDY_CNT_WIDTH'(1);
            last_id_d    = issue_id_q;
          end
        end else if (retract) begin
          issue_valid_d = 1'b0;
          state_d       = SCHED_SEL;
        end
      end
      default: begin
        issue_valid_d = 1'b0;
        state_d       = SCHED_SEL;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      state_q       <= SCHED_SEL;
      issue_valid_q <= 1'b0;
      issue_id_q    <= '0;
      issue_pc_q    <= '0;
      issue_mask_q  <= '0;
      last_id_q     <= '0;
      greedy_cnt_q  <= '0;
      all_done_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      issue_valid_q <= issue_valid_d;
      issue_id_q    <= issue_id_d;
      issue_pc_q    <= issue_pc_d;
      issue_mask_q  <= issue_mask_d;
      last_id_q     <= last_id_d;
      greedy_cnt_q  <= greedy_cnt_d;
      all_done_q    <= all_done_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign issue_valid_o    = issue_valid_q;
  assign issue_warp_id_o  = issue_id_q;
  assign issue_pc_o       = issue_pc_q;
  assign issue_mask_o     = issue_mask_q;
  assign warp_issued_o    = fire;
  assign issued_warp_id_o = issue_id_q;
  assign all_done_o       = all_done_q;

endmodule
